// File: rtl/sev_seg_pkg.sv
// Shared types and helpers for the seven-segment display arbiter.
package sev_seg_pkg;

    localparam int N_DIGITS = 8;
    localparam int DIGIT_W  = 4;

    typedef logic [DIGIT_W-1:0] digit_t;

    typedef enum logic {
        ARB_IDLE,
        ARB_OWNED
    } arb_state_t;

    // Index of the set bit of a one-hot vector; 0 when no bit is set.
    function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/sev_seg_arbiter_rr_pick.sv
// Combinational round-robin search: first candidate at or after last+1, wrapping.
module rr_pick
    import sev_seg_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [2:0]         last,
    input  logic [NUM_REQ-1:0] excl,
    output logic [NUM_REQ-1:0] winner,
    output logic               found
);

    logic [NUM_REQ-1:0] cand;

    assign cand = req & ~excl;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            if (!found && cand[(int'(last) + off) % NUM_REQ]) begin
                winner[(int'(last) + off) % NUM_REQ] = 1'b1;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sev_seg_arbiter.sv
// Round-robin owner of the 8-digit display with a minimum hold time per owner.
//   state     | meaning
//   ARB_IDLE  | no owner, all digits show IDLE_DIGIT
//   ARB_OWNED | grant[owner_idx] set, digits follow that requester's slice
module sev_seg_arbiter
    import sev_seg_pkg::*;
#(
    parameter int     NUM_REQ    = 2,
    parameter int     MIN_HOLD   = 1 << 20,
    parameter digit_t IDLE_DIGIT = 4'h0,
    parameter int     HOLD_W     = $clog2(MIN_HOLD + 1)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ*32-1:0] req_digits,
    output logic [NUM_REQ-1:0]    grant,
    output logic                  owner_valid,
    output logic [2:0]            owner_idx,
    output logic                  owner_changed,
    output digit_t                digits [0:N_DIGITS-1]
);

    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MIN_HOLD - 1);

    arb_state_t         state;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [2:0]         last_idx;

    logic [NUM_REQ-1:0] pick_winner;
    logic               pick_found;
    logic [2:0]         pick_idx;
    logic               owner_req;
    logic               hold_done;
    logic               take_new;
    logic               go_idle;
    logic [2:0]         sel_idx;
    digit_t             sel_view [0:N_DIGITS-1];

    // The current owner is excluded so it can never re-win its own rotation.
    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req    (req),
        .last   (last_idx),
        .excl   (grant),
        .winner (pick_winner),
        .found  (pick_found)
    );

    assign pick_idx  = onehot_to_idx(8'(pick_winner));
    assign owner_req = |(req & grant);
    assign hold_done = (hold_cnt == HOLD_MAX);
    assign take_new  = pick_found && (state == ARB_IDLE || !owner_req || hold_done);
    assign go_idle   = (state == ARB_OWNED) && !owner_req && !pick_found;
    assign sel_idx   = take_new ? pick_idx : owner_idx;

    always_comb begin
        for (int k = 0; k < N_DIGITS; k++) begin
            sel_view[k] = req_digits[(int'(sel_idx) * N_DIGITS + k) * DIGIT_W +: DIGIT_W];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state         <= ARB_IDLE;
            grant         <= '0;
            owner_valid   <= 1'b0;
            owner_idx     <= '0;
            owner_changed <= 1'b0;
            hold_cnt      <= '0;
            last_idx      <= 3'(NUM_REQ - 1);
            for (int k = 0; k < N_DIGITS; k++) digits[k] <= IDLE_DIGIT;
        end else begin
            owner_changed <= take_new || go_idle;
            if (take_new) begin
                state       <= ARB_OWNED;
                grant       <= pick_winner;
                owner_valid <= 1'b1;
                owner_idx   <= pick_idx;
                last_idx    <= pick_idx;
                hold_cnt    <= '0;
                digits      <= sel_view;
            end else if (go_idle) begin
                state       <= ARB_IDLE;
                grant       <= '0;
                owner_valid <= 1'b0;
                owner_idx   <= '0;
                hold_cnt    <= '0;
                for (int k = 0; k < N_DIGITS; k++) digits[k] <= IDLE_DIGIT;
            end else if (state == ARB_OWNED) begin
                digits <= sel_view;
                if (!hold_done) hold_cnt <= hold_cnt + HOLD_W'(1);
            end
        end
    end

endmodule
